mem_port_arbiter: RTL and testbench

Shares the single data/instruction memory port between the fetch stage (IF) and the load/store path of the memory stage (LS). Grants one requester at a time, with at most one transaction outstanding. Issues word-aligned requests with byte enables, and returns responses with load data aligned and sign/zero-extended according to the decoded `mem_size`/`mem_sign`. LS has priority, and a starvation counter bounds how long fetch can be locked out.

---
 rtl/common.sv | 27 ++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types for the memory port arbiter: access sizes, FSM states, request owners
// and the alignment rule used when MEM_ALIGN_CHECK_EN is defined.
package common;

    typedef logic [1:0] mem_size_type;

    localparam mem_size_type MEM_BYTE = 2'b00;
    localparam mem_size_type MEM_HALF = 2'b01;
    localparam mem_size_type MEM_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RSP, ERR} arb_state_type;

    typedef enum logic {OWN_IF, OWN_LS} arb_owner_type;

    // Size 2'b11 is never a legal access when alignment checking is enabled.
    function automatic logic is_misaligned(input mem_size_type size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_BYTE: bad = 1'b0;
            MEM_HALF: bad = off[0];
            MEM_WORD: bad = (off != 2'b00);
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load extract and extension.
module mem_lane_align
    import common::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rsp_size_i,
    input  logic [1:0]  rsp_off_i,
    input  logic        rsp_sign_i,
    input  logic [31:0] rsp_raw_i,
    output logic [31:0] rsp_data_o
);

    logic [15:0] shifted;

    // Word and the undefined size 2'b11 both use the full lane set.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = req_wdata_i;
        case (req_size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = {4{req_wdata_i[7:0]}};
            end
            MEM_HALF: begin
                be_o    = 4'b0011 << {req_off_i[1], 1'b0};
                wdata_o = {2{req_wdata_i[15:0]}};
            end
            MEM_WORD: ;
            default:  ;
        endcase
    end

    // Halfword extraction uses only off[1], so a set off[0] is simply truncated.
    always_comb begin
        shifted    = rsp_raw_i[15:0];
        rsp_data_o = rsp_raw_i;
        case (rsp_size_i)
            MEM_BYTE: begin
                shifted    = 16'(rsp_raw_i >> {rsp_off_i, 3'b000});
                rsp_data_o = {{24{rsp_sign_i & shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                shifted    = 16'(rsp_raw_i >> {rsp_off_i[1], 4'b0000});
                rsp_data_o = {{16{rsp_sign_i & shifted[15]}}, shifted[15:0]};
            end
            MEM_WORD: ;
            default:  ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS), one transaction in flight.
// Define MEM_ALIGN_CHECK_EN to reject misaligned or size-11 LS accesses through the ERR state.
module mem_port_arbiter
    import common::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    input  logic              ls_req_write,
    input  logic [1:0]        ls_req_size,
    input  logic              ls_req_sign,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_err,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [3:0]        mem_req_be,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data
);

    localparam int unsigned CNT_W = 4;

    arb_state_type     state_q;
    arb_owner_type     owner_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [1:0]        off_q;
    logic [CNT_W-1:0]  starve_q;
    logic              mem_req_valid_q;
    logic              mem_req_write_q;
    logic [ADDR_W-1:0] mem_req_addr_q;
    logic [3:0]        mem_req_be_q;
    logic [DATA_W-1:0] mem_req_wdata_q;
    logic              if_rsp_valid_q;
    logic [DATA_W-1:0] if_rsp_data_q;
    logic              ls_rsp_valid_q;
    logic [DATA_W-1:0] ls_rsp_data_q;
    logic              ls_rsp_err_q;

    logic              arb_en_c;
    logic              starved_c;
    logic              grant_if_c;
    logic              grant_ls_c;
    logic              sel_write_c;
    logic              err_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [3:0]        lane_be_c;
    logic [DATA_W-1:0] lane_wdata_c;
    logic [DATA_W-1:0] load_data_c;

    // LS has priority unless fetch has lost STARVE_LIMIT contested rounds in a row.
    assign arb_en_c    = (state_q == IDLE) || (state_q == RSP);
    assign starved_c   = (starve_q == CNT_W'(STARVE_LIMIT));
    assign grant_if_c  = arb_en_c && if_req_valid && (!ls_req_valid || starved_c);
    assign grant_ls_c  = arb_en_c && ls_req_valid && !grant_if_c;
    assign sel_write_c = grant_ls_c && ls_req_write;
    assign sel_addr_c  = grant_if_c ? if_req_addr : ls_req_addr;

`ifdef MEM_ALIGN_CHECK_EN
    assign err_c = grant_ls_c && is_misaligned(ls_req_size, ls_req_addr[1:0]);
`else
    assign err_c = 1'b0;
`endif

    mem_lane_align u_lane (
        .req_size_i  (ls_req_size),
        .req_off_i   (ls_req_addr[1:0]),
        .req_wdata_i (ls_req_wdata),
        .be_o        (lane_be_c),
        .wdata_o     (lane_wdata_c),
        .rsp_size_i  (size_q),
        .rsp_off_i   (off_q),
        .rsp_sign_i  (sign_q),
        .rsp_raw_i   (mem_rsp_data),
        .rsp_data_o  (load_data_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            owner_q         <= OWN_IF;
            write_q         <= 1'b0;
            size_q          <= '0;
            sign_q          <= 1'b0;
            off_q           <= '0;
            starve_q        <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_be_q    <= '0;
            mem_req_wdata_q <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= '0;
            ls_rsp_valid_q  <= 1'b0;
            ls_rsp_data_q   <= '0;
            ls_rsp_err_q    <= 1'b0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
            ls_rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE, RSP: begin
                    state_q <= IDLE;
                    if (grant_if_c || grant_ls_c) begin
                        owner_q <= grant_if_c ? OWN_IF : OWN_LS;
                        write_q <= sel_write_c;
                        size_q  <= grant_if_c ? MEM_WORD : ls_req_size;
                        sign_q  <= grant_ls_c && ls_req_sign;
                        off_q   <= sel_addr_c[1:0];
                        if (grant_if_c) begin
                            starve_q <= '0;
                        end else if (if_req_valid && (starve_q != '1)) begin
                            starve_q <= starve_q + CNT_W'(1);
                        end
                        if (err_c) begin
                            state_q        <= ERR;
                            ls_rsp_valid_q <= 1'b1;
                            ls_rsp_err_q   <= 1'b1;
                        end else begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                            mem_req_write_q <= sel_write_c;
                            mem_req_addr_q  <= {sel_addr_c[ADDR_W-1:2], 2'b00};
                            mem_req_be_q    <= sel_write_c ? lane_be_c : 4'b1111;
                            mem_req_wdata_q <= sel_write_c ? lane_wdata_c : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state_q <= RSP;
                        if (owner_q == OWN_IF) begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_data_q  <= mem_rsp_data;
                        end else begin
                            ls_rsp_valid_q <= 1'b1;
                            ls_rsp_data_q  <= write_q ? '0 : load_data_c;
                        end
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_req_ready  = grant_if_c;
    assign ls_req_ready  = grant_ls_c;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_data   = ls_rsp_data_q;
    assign ls_rsp_err    = ls_rsp_err_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_be    = mem_req_be_q;
    assign mem_req_wdata = mem_req_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases, randomized LS traffic against a
// lane-level reference model, starvation ordering and reset abort.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_write = 1'b0;
    logic [1:0]  ls_req_size = '0;
    logic        ls_req_sign = 1'b0;
    logic [31:0] ls_req_addr = '0;
    logic [31:0] ls_req_wdata = '0;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_be;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;

    int checks = 0;
    int errors = 0;

    // Memory responder knobs and observations.
    int          ready_dly = 0;
    int          rsp_dly = 0;
    logic [31:0] rsp_word = '0;
    int          mem_req_cnt = 0;
    int          stall_bad = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_write = 1'b0;

    logic [138:0] all_outs;
    assign all_outs = {if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid,
                       ls_rsp_data, ls_rsp_err, mem_req_valid, mem_req_write, mem_req_addr,
                       mem_req_be, mem_req_wdata};

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_write  (ls_req_write),
        .ls_req_size   (ls_req_size),
        .ls_req_sign   (ls_req_sign),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_ready  (ls_req_ready),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .ls_rsp_err    (ls_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_be    (mem_req_be),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    always #5 clk = ~clk;

    // Memory model: stalls ready for ready_dly cycles, answers rsp_dly cycles after acceptance.
    always begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (mem_req_valid === 1'b1) begin
            cap_addr  = mem_req_addr;
            cap_wdata = mem_req_wdata;
            cap_be    = mem_req_be;
            cap_write = mem_req_write;
            for (int i = 0; i < ready_dly; i++) begin
                @(negedge clk);
                if (mem_req_valid !== 1'b1 || mem_req_addr !== cap_addr || mem_req_be !== cap_be ||
                    mem_req_wdata !== cap_wdata || mem_req_write !== cap_write)
                    stall_bad++;
            end
            mem_req_ready = 1'b1;
            mem_req_cnt++;
            @(negedge clk);
            mem_req_ready = 1'b0;
            for (int i = 0; i < rsp_dly; i++) @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rsp_word;
        end
    end

    function automatic int model_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int model_start(input logic [1:0] sz, input logic [1:0] off);
        int n;
        n = model_bytes(sz);
        return (int'(off) / n) * n;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int n, s;
        n = model_bytes(sz);
        s = model_start(sz, off);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(s+i) +: 8];
        if (sg && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        int n, s;
        n = model_bytes(sz);
        s = model_start(sz, off);
        be = '0;
        for (int i = s; i < s + n; i++) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] v;
        int n;
        n = model_bytes(sz);
        for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % n) +: 8];
        return v;
    endfunction

    // Drives one request and reports grant/response cycles relative to the request cycle.
    task automatic run_txn(input bit use_if, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] word,
                           output int rdy_cyc, output int rsp_cyc,
                           output logic [31:0] data, output logic err);
        bit granted;
        granted  = 1'b0;
        rdy_cyc  = -1;
        rsp_cyc  = -1;
        data     = '0;
        err      = 1'b0;
        rsp_word = word;
        @(negedge clk);
        if (use_if) begin
            if_req_valid = 1'b1;
            if_req_addr  = addr;
        end else begin
            ls_req_valid = 1'b1;
            ls_req_write = wr;
            ls_req_size  = sz;
            ls_req_sign  = sg;
            ls_req_addr  = addr;
            ls_req_wdata = wd;
        end
        for (int cyc = 0; cyc < 40 && rsp_cyc < 0; cyc++) begin
            #1;
            if (!granted && (use_if ? if_req_ready : ls_req_ready) === 1'b1) begin
                rdy_cyc = cyc;
                granted = 1'b1;
            end
            if ((use_if ? if_rsp_valid : ls_rsp_valid) === 1'b1) begin
                rsp_cyc = cyc;
                data    = use_if ? if_rsp_data : ls_rsp_data;
                err     = ls_rsp_err;
            end
            @(negedge clk);
            if (granted) begin
                if_req_valid = 1'b0;
                ls_req_valid = 1'b0;
            end
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_held_outputs: got %h expected 0", all_outs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_idle_outputs: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_if_fetch();
        int rdy, rsp;
        logic [31:0] d;
        logic e;
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, '0, 32'h00A0_0093, rdy, rsp, d, e);
        checks++;
        if (rdy !== 0) begin errors++; $display("FAIL if_ready_cycle: got %0d expected 0", rdy); end
        checks++;
        if (rsp !== 3) begin errors++; $display("FAIL if_rsp_cycle: got %0d expected 3", rsp); end
        checks++;
        if (d !== 32'h00A0_0093) begin errors++; $display("FAIL if_rsp_data: got %h expected 00a00093", d); end
        checks++;
        if (cap_addr !== 32'h0000_0104) begin errors++; $display("FAIL if_mem_addr: got %h expected 00000104", cap_addr); end
        checks++;
        if (cap_be !== 4'b1111 || cap_write !== 1'b0) begin
            errors++; $display("FAIL if_mem_be_write: got be=%b wr=%b expected be=1111 wr=0", cap_be, cap_write);
        end
    endtask

    task automatic test_load_byte();
        int rdy, rsp;
        logic [31:0] d;
        logic e;
        run_txn(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0203, '0, 32'h80FF_7F01, rdy, rsp, d, e);
        checks++;
        if (cap_be !== 4'b1111) begin errors++; $display("FAIL lb_be: got %b expected 1111", cap_be); end
        checks++;
        if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_signed_data: got %h expected ffffff80", d); end
        checks++;
        if (rsp !== 3 || e !== 1'b0) begin errors++; $display("FAIL lb_rsp: got cyc=%0d err=%b expected cyc=3 err=0", rsp, e); end
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0203, '0, 32'h80FF_7F01, rdy, rsp, d, e);
        checks++;
        if (d !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", d); end
    endtask

    task automatic test_store_half();
        int rdy, rsp;
        logic [31:0] d;
        logic e;
        run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h1234_ABCD, 32'hDEAD_BEEF, rdy, rsp, d, e);
        checks++;
        if (cap_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b expected 1100", cap_be); end
        checks++;
        if (cap_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcdabcd", cap_wdata); end
        checks++;
        if (cap_addr !== 32'h0000_0300 || cap_write !== 1'b1) begin
            errors++; $display("FAIL sh_addr_write: got %h/%b expected 00000300/1", cap_addr, cap_write);
        end
        checks++;
        if (rsp !== 3 || d !== 32'h0) begin errors++; $display("FAIL sh_rsp: got cyc=%0d data=%h expected cyc=3 data=0", rsp, d); end
    endtask

    task automatic test_misaligned();
        int rdy, rsp, cnt0;
        logic [31:0] d;
        logic e;
        cnt0 = mem_req_cnt;
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0401, '0, 32'hCAFE_F00D, rdy, rsp, d, e);
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (rsp !== 1 || e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL mis_err_rsp: got cyc=%0d err=%b data=%h expected cyc=1 err=1 data=0", rsp, e, d);
        end
        checks++;
        if (mem_req_cnt !== cnt0) begin errors++; $display("FAIL mis_no_mem_req: got %0d expected %0d", mem_req_cnt, cnt0); end
`else
        checks++;
        if (cap_addr !== 32'h0000_0400 || mem_req_cnt !== cnt0 + 1) begin
            errors++; $display("FAIL mis_addr: got %h n=%0d expected 00000400 n=%0d", cap_addr, mem_req_cnt, cnt0 + 1);
        end
        checks++;
        if (rsp !== 3 || e !== 1'b0 || d !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL mis_rsp: got cyc=%0d err=%b data=%h expected cyc=3 err=0 data=cafef00d", rsp, e, d);
        end
`endif
    endtask

    task automatic test_random_ls();
        int rdy, rsp, cnt0, exp_cyc;
        logic [31:0] d, addr, wd, word, exp_d;
        logic e, wr, sg, exp_err;
        logic [1:0] sz;
        for (int t = 0; t < 24; t++) begin
            wr        = 1'($urandom_range(0, 1));
            sg        = 1'($urandom_range(0, 1));
            sz        = 2'($urandom_range(0, 3));
            addr      = $urandom();
            wd        = $urandom();
            word      = $urandom();
            ready_dly = $urandom_range(0, 2);
            rsp_dly   = $urandom_range(0, 2);
`ifdef MEM_ALIGN_CHECK_EN
            exp_err = (sz == 2'b11) || ((int'(addr[1:0]) % model_bytes(sz)) != 0);
`else
            exp_err = 1'b0;
`endif
            cnt0 = mem_req_cnt;
            run_txn(1'b0, wr, sz, sg, addr, wd, word, rdy, rsp, d, e);
            exp_cyc = exp_err ? 1 : 3 + ready_dly + rsp_dly;
            exp_d   = (exp_err || wr) ? 32'h0 : model_load(word, addr[1:0], sz, sg);
            checks++;
            if (rsp !== exp_cyc || e !== exp_err) begin
                errors++; $display("FAIL rand_rsp[%0d]: got cyc=%0d err=%b expected cyc=%0d err=%b", t, rsp, e, exp_cyc, exp_err);
            end
            checks++;
            if (d !== exp_d) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", t, d, exp_d); end
            if (exp_err) begin
                checks++;
                if (mem_req_cnt !== cnt0) begin errors++; $display("FAIL rand_no_req[%0d]: got %0d expected %0d", t, mem_req_cnt, cnt0); end
            end else begin
                checks++;
                if (cap_addr !== {addr[31:2], 2'b00} || cap_write !== wr) begin
                    errors++; $display("FAIL rand_addr[%0d]: got %h/%b expected %h/%b", t, cap_addr, cap_write, {addr[31:2], 2'b00}, wr);
                end
                checks++;
                if (cap_be !== (wr ? model_be(sz, addr[1:0]) : 4'b1111)) begin
                    errors++; $display("FAIL rand_be[%0d]: got %b expected %b", t, cap_be, wr ? model_be(sz, addr[1:0]) : 4'b1111);
                end
                if (wr) begin
                    checks++;
                    if (cap_wdata !== model_wdata(sz, wd)) begin
                        errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", t, cap_wdata, model_wdata(sz, wd));
                    end
                end
            end
        end
        ready_dly = 0;
        rsp_dly   = 0;
    endtask

    task automatic test_starve();
        int ngr, bad_grant, stall0;
        bit exp_if;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        ready_dly = 5;
        rsp_dly   = 0;
        stall0    = stall_bad;
        ngr       = 0;
        bad_grant = 0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0700;
        ls_req_valid = 1'b1;
        ls_req_write = 1'b0;
        ls_req_size  = 2'b10;
        ls_req_sign  = 1'b0;
        ls_req_addr  = 32'h0000_0600;
        for (int cyc = 0; cyc < 300 && ngr < 7; cyc++) begin
            #1;
            if (mem_req_valid === 1'b1 && (if_req_ready === 1'b1 || ls_req_ready === 1'b1)) bad_grant++;
            if (if_req_ready === 1'b1 || ls_req_ready === 1'b1) begin
                exp_if = (ngr % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
                checks++;
                if (if_req_ready !== exp_if || ls_req_ready !== !exp_if) begin
                    errors++; $display("FAIL starve_order[%0d]: got if=%b ls=%b expected if=%b ls=%b", ngr, if_req_ready, ls_req_ready, exp_if, !exp_if);
                end
                ngr++;
            end
            @(negedge clk);
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        checks++;
        if (ngr !== 7) begin errors++; $display("FAIL starve_grant_count: got %0d expected 7", ngr); end
        checks++;
        if (bad_grant !== 0) begin errors++; $display("FAIL stall_no_grant: got %0d expected 0", bad_grant); end
        checks++;
        if (stall_bad !== stall0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_bad - stall0); end
        repeat (20) @(negedge clk);
        ready_dly = 0;
    endtask

    task automatic test_reset_abort();
        int pulses, mreqs;
        rsp_dly  = 4;
        rsp_word = 32'h1357_9BDF;
        pulses   = 0;
        mreqs    = 0;
        @(negedge clk);
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0000_0500;
        #1;
        checks++;
        if (if_req_ready !== 1'b1) begin errors++; $display("FAIL abort_grant: got %b expected 1", if_req_ready); end
        @(negedge clk);
        if_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL abort_async_outputs: got %h expected 0", all_outs); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (if_rsp_valid !== 1'b0 || ls_rsp_valid !== 1'b0) pulses++;
            if (mem_req_valid !== 1'b0) mreqs++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0 || mreqs !== 0) begin
            errors++; $display("FAIL abort_no_rsp: got rsp=%0d req=%0d expected 0/0", pulses, mreqs);
        end
        #1;
        checks++;
        if (all_outs !== '0) begin errors++; $display("FAIL abort_idle_outputs: got %h expected 0", all_outs); end
        rsp_dly = 0;
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_random_ls();
        test_starve();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
